// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, constants and segment lookup for the BCD scanner.
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam int NUM_SLOTS = 4;
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = 7'b1000000;
      4'd1: seg_of = 7'b1111001;
      4'd2: seg_of = 7'b0100100;
      4'd3: seg_of = 7'b0110000;
      4'd4: seg_of = 7'b0011001;
      4'd5: seg_of = 7'b0010010;
      4'd6: seg_of = 7'b0000010;
      4'd7: seg_of = 7'b1111000;
      4'd8: seg_of = 7'b0000000;
      4'd9: seg_of = 7'b0010000;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: input register plus sequential double-dabble binary-to-BCD converter.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  valor,
  output logic [11:0] bcd,
  output logic        busy
);
  logic [7:0] valor_q, conv_src, cap, sr;
  logic [11:0] scr, adj;
  logic [2:0] iter;
  conv_state_t state;
  always_comb
    adj = {scr[11:8] >= 4'd5 ? scr[11:8] + 4'd3 : scr[11:8],
           scr[7:4]  >= 4'd5 ? scr[7:4]  + 4'd3 : scr[7:4],
           scr[3:0]  >= 4'd5 ? scr[3:0]  + 4'd3 : scr[3:0]};
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      valor_q  <= '0;
      conv_src <= '0;
      cap      <= '0;
      sr       <= '0;
      scr      <= '0;
      iter     <= '0;
      bcd      <= '0;
      state    <= IDLE;
    end else begin
      valor_q <= valor;
      case (state)
        IDLE: if (valor_q != conv_src) begin
          sr    <= valor_q;
          cap   <= valor_q;
          scr   <= '0;
          iter  <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          {scr, sr} <= {adj, sr} << 1;
          iter      <= iter + 3'd1;
          if (iter == 3'd7) state <= DONE;
        end
        DONE: begin
          bcd      <= scr;
          conv_src <= cap;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/seg7_bcd_scanner.sv
// seg7_bcd_scanner: BCD conversion of a binary count, multiplexed onto a
// 4-digit common-anode display with leading-zero blanking.
module seg7_bcd_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int WIDTH       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] valor,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic [11:0]      bcd,
  output logic             busy
);
  localparam int CW = REFRESH_DIV > 2 ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = $clog2(NUM_SLOTS);
  logic [CW-1:0] cnt;
  logic [SW-1:0] slot;
  logic [3:0] digit, an_n;
  logic [6:0] seg_n;
  logic blank;
  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .valor (valor),
    .bcd   (bcd),
    .busy  (busy)
  );
  always_comb begin
    digit = slot == 2'd0 ? bcd[3:0] : slot == 2'd1 ? bcd[7:4] : bcd[11:8];
    blank = slot == 2'd3 || (slot == 2'd1 && bcd[11:4] == 8'd0) || (slot == 2'd2 && bcd[11:8] == 4'd0);
    an_n  = slot == 2'd3 ? 4'b1111 : ~(4'b0001 << slot);
    seg_n = blank ? SEG_BLANK : seg_of(digit);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      slot <= '0;
      an   <= 4'b1111;
      seg  <= SEG_BLANK;
    end else begin
      cnt  <= cnt == CW'(REFRESH_DIV - 1) ? '0 : cnt + 1'b1;
      slot <= cnt == CW'(REFRESH_DIV - 1) ? slot + 1'b1 : slot;
      an   <= an_n;
      seg  <= seg_n;
    end
  end
endmodule

// File: tb/tb_seg7_bcd_scanner.sv
// tb_seg7_bcd_scanner: scoreboard bench; stimulus predicts committed BCD values,
// a monitor checks every bcd change, and frame sweeps check the multiplexed display.
module tb_seg7_bcd_scanner;
  localparam int DIV = 4;
  localparam logic [6:0] SEGS [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic clk = 0, rst = 0;
  logic [7:0] valor = 8'd255;
  logic [6:0] seg;
  logic [3:0] an;
  logic [11:0] bcd;
  logic busy;
  int n_chk = 0, n_fail = 0;
  logic [11:0] expq [$];
  logic [11:0] prev_bcd = '0;
  logic rst_edge = 0;
  logic [7:0] model_last = '0;

  always #5 clk = ~clk;

  seg7_bcd_scanner #(.REFRESH_DIV(DIV), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .valor(valor), .seg(seg), .an(an), .bcd(bcd), .busy(busy)
  );

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] next_an(input logic [3:0] a);
    return a == 4'b1110 ? 4'b1101 : a == 4'b1101 ? 4'b1011 : a == 4'b1011 ? 4'b1111 : 4'b1110;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int v);
    if (8'(v) != model_last) begin
      expq.push_back(to_bcd(v));
      model_last = 8'(v);
    end
  endtask

  task automatic wait_bcd(input int v);
    int k = 0;
    while (bcd !== to_bcd(v) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("wait_bcd", {20'd0, bcd}, {20'd0, to_bcd(v)});
  endtask

  task automatic check_frame(input int v);
    int cnt [4] = '{0, 0, 0, 0};
    logic [3:0] pa = 4'b0000;
    logic [11:0] d = to_bcd(v);
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (i > 0 && an != pa) check("an_order", {28'd0, an}, {28'd0, next_an(pa)});
      pa = an;
      case (an)
        4'b1110: begin check("seg_units", {25'd0, seg}, {25'd0, SEGS[d[3:0]]}); cnt[0]++; end
        4'b1101: begin check("seg_tens", {25'd0, seg}, {25'd0, v < 10 ? 7'b1111111 : SEGS[d[7:4]]}); cnt[1]++; end
        4'b1011: begin check("seg_hund", {25'd0, seg}, {25'd0, v < 100 ? 7'b1111111 : SEGS[d[11:8]]}); cnt[2]++; end
        4'b1111: begin check("seg_off", {25'd0, seg}, {25'd0, 7'b1111111}); cnt[3]++; end
        default: check("an_pattern", {28'd0, an}, {28'd0, 4'b1110});
      endcase
    end
    for (int s = 0; s < 4; s++) check("slot_len", cnt[s], DIV);
  endtask

  always @(posedge clk) rst_edge <= rst;

  always @(negedge clk) begin
    if (!rst_edge) prev_bcd = bcd;
    else if (bcd !== prev_bcd) begin
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL bcd_unexpected: got %0h, expected no change from %0h", bcd, prev_bcd);
      end else check("bcd_commit", {20'd0, bcd}, {20'd0, expq.pop_front()});
      prev_bcd = bcd;
    end
  end

  initial begin
    int v, k;
    repeat (5) begin
      @(negedge clk);
      check("rst_an", {28'd0, an}, {28'd0, 4'b1111});
      check("rst_seg", {25'd0, seg}, {25'd0, 7'b1111111});
      check("rst_bcd", {20'd0, bcd}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    rst = 1;
    push(255);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i == 1) check("first_an", {28'd0, an}, {28'd0, 4'b1110});
      if (i == 2) check("busy_start", {31'd0, busy}, 32'd1);
      if (i == 10) begin
        check("busy_end", {31'd0, busy}, 32'd1);
        check("bcd_early", {20'd0, bcd}, 32'd0);
      end
      if (i == 11) check("bcd_255", {20'd0, bcd}, {20'd0, 12'h255});
    end
    check_frame(255);
    valor = 8'd7;
    push(7);
    wait_bcd(7);
    check_frame(7);
    repeat (6) begin
      @(negedge clk);
      check("same_no_busy", {31'd0, busy}, 32'd0);
    end
    valor = 8'd100;
    push(100);
    repeat (3) @(negedge clk);
    valor = 8'd200;
    push(200);
    wait_bcd(100);
    check("gap_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("gap_rebusy", {31'd0, busy}, 32'd1);
    wait_bcd(200);
    valor = 8'd0;
    push(0);
    wait_bcd(0);
    check_frame(0);
    repeat (12) begin
      v = int'($urandom_range(0, 255));
      if (v == 99) v = 98;
      valor = 8'(v);
      push(v);
      repeat (14) @(negedge clk);
      check("rand_bcd", {20'd0, bcd}, {20'd0, to_bcd(v)});
      check_frame(v);
    end
    valor = 8'd99;
    k = 0;
    while (!busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("busy_99", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 0;
    model_last = '0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_bcd", {20'd0, bcd}, 32'd0);
    check("abort_an", {28'd0, an}, {28'd0, 4'b1111});
    rst = 1;
    push(99);
    wait_bcd(99);
    repeat (3) @(negedge clk);
    check("queue_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
